// File: rtl/core_sequencer.sv
// core_sequencer: configurable phase sequencer for the multicycle RV32 core.
// Latency: NUM_PHASES cycles per instruction, plus one cycle per mem_wait cycle seen in MEM_PHASE.
// Backpressure: mem_wait parks the sequence in MEM_PHASE; halt/step park it at instruction boundaries.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   mem_wait         memory not ready (looked at only in MEM_PHASE while running/stalled)
//   halt_req         level request to park at the next instruction boundary
//   step_req         one-cycle pulse, runs exactly one instruction while halted
//   retire_clr       synchronous clear of retire_cnt (wins over a coincident retire)
//   hold_if/mem/reg  freeze controls for InstFetch, MemoryAccess and the register file
//   phase            current phase index
//   halted           sequencer is parked at a boundary
//   retire           one-cycle pulse in the write-back phase
//   retire_cnt       free-running count of retired instructions
module core_sequencer #(
  parameter int NUM_PHASES = 8,
  parameter int CNT_W      = 4,
  parameter int IF_PHASE   = 0,
  parameter int MEM_PHASE  = 4,
  parameter int WB_PHASE   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_wait,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             retire_clr,
  output logic             hold_if,
  output logic             hold_mem,
  output logic             hold_reg,
  output logic [CNT_W-1:0] phase,
  output logic             halted,
  output logic             retire,
  output logic [31:0]      retire_cnt
);

  // Reject parameter sets that would make the phase map inconsistent.
  if (NUM_PHASES < 4 || NUM_PHASES > 16 || (2 ** CNT_W) < NUM_PHASES ||
      IF_PHASE != 0 || !(IF_PHASE < MEM_PHASE && MEM_PHASE < WB_PHASE) ||
      WB_PHASE > NUM_PHASES - 1) begin : g_bad_params
    $error("core_sequencer: illegal phase parameters");
  end

  localparam logic [CNT_W-1:0] LAST_P = CNT_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] IF_P   = CNT_W'(IF_PHASE);
  localparam logic [CNT_W-1:0] MEM_P  = CNT_W'(MEM_PHASE);
  localparam logic [CNT_W-1:0] WB_P   = CNT_W'(WB_PHASE);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] phase_nxt;
  logic             step_pending, step_pending_nxt;

  // Next-state / next-phase logic.
  always_comb begin
    state_nxt        = state;
    phase_nxt        = phase;
    step_pending_nxt = step_pending;
    case (state)
      RUN: begin
        if (phase == MEM_P && mem_wait) begin
          // Phase stays put; the memory keeps its request up while we wait.
          state_nxt = STALL;
        end else if (phase == LAST_P) begin
          // Instruction boundary: the only place a halt may take effect.
          phase_nxt = '0;
          if (halt_req || step_pending) begin
            state_nxt        = HALT;
            step_pending_nxt = 1'b0;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      STALL: begin
        // Leaving the stall also performs the MEM -> MEM+1 advance.
        if (!mem_wait) begin
          state_nxt = RUN;
          phase_nxt = MEM_P + 1'b1;
        end
      end
      HALT: begin
        phase_nxt = '0;
        if (step_req) begin
          // Run one instruction; the pending flag forces a re-halt at its end
          // even if halt_req has since dropped.
          step_pending_nxt = 1'b1;
          state_nxt        = RUN;
        end else if (!halt_req) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      phase        <= '0;
      step_pending <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      step_pending <= step_pending_nxt;
      if (retire_clr) begin
        retire_cnt <= '0;
      end else if (retire) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  // Holds are decoded straight from registered state, so they only move on edges.
  // MemoryAccess stays enabled through STALL so its request remains asserted.
  assign hold_if  = !(state == RUN && phase == IF_P);
  assign hold_mem = !((state == RUN || state == STALL) && phase == MEM_P);
  assign hold_reg = !(state == RUN && phase == WB_P);
  assign retire   = !hold_reg;
  assign halted   = (state == HALT);

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Parametrised phase sequencer for the multicycle RV32 core. It replaces the fixed 3-bit free-running phase counter in the core top with a configurable phase count and programmable IF/MEM/WB phase positions. It also adds three things: memory wait-state stalling, debug halt/single-step at instruction boundaries, and a retired-instruction counter. It drives the `hold` inputs of InstFetch, MemoryAccess and Registers.

## Interface
- `NUM_PHASES`, 8, cycles per instruction; legal range 4..16.
- `CNT_W`, 4, phase counter width; must satisfy 2^CNT_W >= NUM_PHASES.
- `IF_PHASE`, 0, phase in which the PC advances (hold_if low); fixed at 0.
- `MEM_PHASE`, 4, phase in which MemoryAccess is enabled; IF_PHASE < MEM_PHASE < WB_PHASE.
- `WB_PHASE`, 5, phase in which the register file writes; WB_PHASE <= NUM_PHASES-1.
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `mem_wait`  in  1  memory not ready; sampled only in MEM_PHASE.
- `halt_req`  in  1  level request to halt at the next instruction boundary.
- `step_req`  in  1  one-cycle pulse; executes one instruction while halted.
- `retire_clr`  in  1  synchronously clears retire_cnt.
- `hold_if`  out  1  1 = InstFetch frozen.
- `hold_mem`  out  1  1 = MemoryAccess frozen.
- `hold_reg`  out  1  1 = register write blocked.
- `phase`  out  CNT_W  current phase index.
- `halted`  out  1  core is parked at a boundary.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retire_cnt`  out  32  count of retired instructions.

## Operation
- The state register has three states: RUN, STALL, HALT. The phase register counts 0..NUM_PHASES-1.
- **RUN:**
  - Phase increments each cycle.
  - At NUM_PHASES-1 the phase wraps to 0. This wrap is the instruction boundary.
  - In MEM_PHASE with mem_wait=1, go to STALL; the phase does not advance.
- **STALL:**
  - The phase stays at MEM_PHASE.
  - When mem_wait=0, return to RUN and advance to MEM_PHASE+1 in the same cycle.
  - While stalled, hold_mem=0 so the memory keeps its request active. hold_if=1 and hold_reg=1.
- **HALT:**
  - Phase=0 and all holds=1.
  - A step_req pulse arms step_pending and enters RUN at phase 0.
  - halt_req=0 enters RUN at phase 0.
- **Boundary rule:** at the wrap, if halt_req=1 or step_pending=1, go to HALT instead of phase 0 in RUN, and clear step_pending.
- **Halt timing:** halt_req is never honoured mid-instruction. Asserting it during STALL still completes the instruction first.
- **Hold decode** (combinational from registered state/phase):
  - hold_if = !(state==RUN && phase==IF_PHASE).
  - hold_mem = !((state==RUN || state==STALL) && phase==MEM_PHASE).
  - hold_reg = !(state==RUN && phase==WB_PHASE).
- **Retire:**
  - `retire` is 1 in the WB_PHASE cycle in RUN, i.e. whenever hold_reg=0.
  - retire_cnt increments on that cycle and wraps 0xFFFFFFFF -> 0.
  - If retire_clr and retire coincide, retire_cnt becomes 0; clear wins.
- **Simultaneous events:**
  - step_req while in RUN is ignored.
  - step_req together with halt_req=1 in HALT executes exactly one instruction, then re-halts.
  - step_req with halt_req=0 in HALT resumes free run; step_pending still forces a halt at the next boundary.

## Timing
- **Reset values:** state=RUN, phase=0, step_pending=0, retire_cnt=0. Outputs: hold_if=0, hold_mem=1, hold_reg=1, halted=0, retire=0.
- **Reset mid-operation:** reset in any state, including STALL or HALT, returns to these values on the next edge. mem_wait is ignored during reset.
- **Instruction latency:** exactly NUM_PHASES cycles with no wait states, plus one cycle per cycle of mem_wait=1 observed in MEM_PHASE.
- **Hold outputs:** zero-latency decode of registered state; they change only on clk edges.
- **halted:**
  - Asserts in the cycle after the boundary edge; the first HALT cycle shows halted=1, phase=0.
  - Deasserts in the cycle after the step_req or halt_req=0 that triggers resume.
- **mem_wait sampling:** sampled only when phase==MEM_PHASE and state is RUN or STALL; the value at all other times is don't-care.
- Minimum STALL dwell is 1 cycle.

## Test plan
- Default params, no stimulus after reset:
  - hold_if low at cycles 0, 8, 16.
  - hold_mem low at cycles 4, 12.
  - hold_reg/retire high at cycles 5, 13.
  - retire_cnt=3 after cycle 21.
- mem_wait=1 for 3 cycles starting at phase 4:
  - phase reads 4 for 4 cycles with hold_mem=0 throughout.
  - the next hold_if low occurs at cycle 11 instead of 8.
- halt_req raised at phase 2 and held: instruction completes (retire at phase 5), then halted=1 and phase=0 at the boundary, with all holds 1 for 20 cycles.
- While halted (halt_req=1), two step_req pulses 20 cycles apart:
  - each yields exactly one hold_if low and one retire pulse.
  - returns to halted=1; retire_cnt advances by exactly 2.
- NUM_PHASES=5, MEM_PHASE=2, WB_PHASE=4, CNT_W=3:
  - period is 5 cycles; retire at phase 4.
  - phase wraps 4 -> 0.
- retire_cnt preset near wrap (run 2^32-1 retires via force) plus retire_clr coincident with retire: retire_cnt=0 on both wrap and clear.
